sample_hold_ctrl: RTL and testbench

Digital sequencer that drives the `ena` and `hold` pins of the `sample_and_hold` analog macro and hands each held sample to a downstream ADC through a req/ack handshake. It runs in the 1.8 V core domain. It enforces three timings: macro power-up (wake), a minimum acquisition (track) time between samples, and hold-settling before conversion is requested. Software or a trigger block issues single-cycle `start` pulses; the controller returns `done` when the ADC has acknowledged the conversion.

---
 rtl/sample_hold_ctrl_pkg.sv | 16 +
 rtl/sample_hold_ctrl_if.sv | 38 +++
 rtl/sample_hold_ctrl_timer.sv | 34 +++
 rtl/sample_hold_ctrl.sv | 151 +++++++++++++++
 tb/tb_sample_hold_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/sample_hold_ctrl_pkg.sv
// sample_hold_pkg: shared types and defaults for the sample-and-hold sequencer.
//   CNT_W_DEFAULT : default width of the timing fields and internal counters
//   sh_state_t    : sequencer states (OFF, WAKE, TRACK, SETTLE, CONV)
package sample_hold_pkg;

  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    OFF    = 3'd0,
    WAKE   = 3'd1,
    TRACK  = 3'd2,
    SETTLE = 3'd3,
    CONV   = 3'd4
  } sh_state_t;

endpackage

// File: rtl/sample_hold_ctrl_if.sv
// sample_hold_ctrl_if: control, timing and ADC handshake bundle of the
// sample-and-hold sequencer.
//   master : the side issuing start/enable/timings and returning conv_ack
//   slave  : the sequencer (drives macro pins, conv_req and status pulses)
// Signals:
//   enable, start, t_wake, t_acq, t_settle, conv_ack        master -> slave
//   sh_ena, sh_hold, conv_req, ready, busy, done, overrun   slave  -> master
interface sample_hold_ctrl_if
  import sample_hold_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) ();

  logic             enable;
  logic             start;
  logic [CNT_W-1:0] t_wake;
  logic [CNT_W-1:0] t_acq;
  logic [CNT_W-1:0] t_settle;
  logic             conv_ack;
  logic             sh_ena;
  logic             sh_hold;
  logic             conv_req;
  logic             ready;
  logic             busy;
  logic             done;
  logic             overrun;

  modport master (
    output enable, start, t_wake, t_acq, t_settle, conv_ack,
    input  sh_ena, sh_hold, conv_req, ready, busy, done, overrun
  );

  modport slave (
    input  enable, start, t_wake, t_acq, t_settle, conv_ack,
    output sh_ena, sh_hold, conv_req, ready, busy, done, overrun
  );

endinterface

// File: rtl/sample_hold_ctrl_timer.sv
// sh_timer: loadable down-counter shared by the WAKE and SETTLE phases.
//   clk, resetn : clock, asynchronous active-low reset
//   load        : capture value (a value of 0 is treated as 1)
//   value       : phase length in cycles
//   expired     : high in the last cycle of the loaded phase
// After a load of L the counter shows L, L-1, ... 1, so expired is seen
// exactly L cycles after the load edge, in the phase's final cycle.
module sh_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             expired
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= (value == '0) ? ONE : value;
    end else if (count_reg > ONE) begin
      count_reg <= count_reg - ONE;
    end
  end

  assign expired = (count_reg <= ONE);

endmodule

// File: rtl/sample_hold_ctrl.sv
// sample_hold_ctrl: drives ena/hold of the sample_and_hold macro and hands
// each held sample to the ADC via a conv_req/conv_ack handshake.
//   clk    : single clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : sample_hold_ctrl_if.slave (enable/start/timings/conv_ack in,
//            sh_ena/sh_hold/conv_req/ready/busy/done/overrun out)
// All outputs come straight from flops, computed from the next state.
module sample_hold_ctrl
  import sample_hold_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input logic               clk,
  input logic               resetn,
  sample_hold_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] SAT = '1;

  sh_state_t        state_reg, state_next;
  logic [CNT_W-1:0] acq_cnt_reg, acq_cnt_next;
  logic             pending_reg, pending_next;

  logic sh_ena_reg, sh_hold_reg, conv_req_reg, ready_reg, busy_reg, done_reg, overrun_reg;
  logic sh_ena_next, sh_hold_next, conv_req_next, ready_next, busy_next, done_next, overrun_next;

  logic [CNT_W-1:0] acq_min;
  logic [CNT_W-1:0] timer_value;
  logic             acq_ok;
  logic             take;
  logic             timer_load;
  logic             timer_expired;

  // A zero acquisition time still needs one tracking cycle.
  assign acq_min = (bus.t_acq == '0) ? ONE : bus.t_acq;
  assign acq_ok  = (acq_cnt_reg >= acq_min);

  sh_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .resetn  (resetn),
    .load    (timer_load),
    .value   (timer_value),
    .expired (timer_expired)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= OFF;
      acq_cnt_reg  <= '0;
      pending_reg  <= 1'b0;
      sh_ena_reg   <= 1'b0;
      sh_hold_reg  <= 1'b0;
      conv_req_reg <= 1'b0;
      ready_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      acq_cnt_reg  <= acq_cnt_next;
      pending_reg  <= pending_next;
      sh_ena_reg   <= sh_ena_next;
      sh_hold_reg  <= sh_hold_next;
      conv_req_reg <= conv_req_next;
      ready_reg    <= ready_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      overrun_reg  <= overrun_next;
    end
  end

  // Next-state logic. take marks the cycle a sample begins; a queued start
  // is served as soon as acquisition time is met, a fresh one only if none
  // is queued.
  always_comb begin
    state_next = state_reg;
    take       = 1'b0;
    if (!bus.enable) begin
      state_next = OFF;
    end else begin
      case (state_reg)
        OFF:    state_next = WAKE;
        WAKE:   if (timer_expired) state_next = TRACK;
        TRACK: begin
          if (acq_ok && (bus.start || pending_reg)) begin
            state_next = SETTLE;
            take       = 1'b1;
          end
        end
        SETTLE: if (timer_expired) state_next = CONV;
        CONV:   if (bus.conv_ack) state_next = TRACK;
        default: state_next = OFF;
      endcase
    end
  end

  // Datapath and output decode.
  always_comb begin
    pending_next = pending_reg;
    acq_cnt_next = acq_cnt_reg;
    overrun_next = 1'b0;
    done_next    = 1'b0;
    timer_load   = 1'b0;
    timer_value  = bus.t_wake;
    if (!bus.enable) begin
      pending_next = 1'b0;
    end else begin
      if (state_reg == OFF) begin
        timer_load = 1'b1;
      end
      if (take) begin
        timer_load  = 1'b1;
        timer_value = bus.t_settle;
      end
      // Starts in OFF are ignored; any other start finding the single
      // queue slot occupied is dropped.
      if (bus.start && (state_reg != OFF) && pending_reg) begin
        overrun_next = 1'b1;
      end
      if (take) begin
        pending_next = 1'b0;
      end else if (bus.start && (state_reg != OFF)) begin
        pending_next = 1'b1;
      end
      if (state_next == TRACK) begin
        if (state_reg != TRACK) begin
          acq_cnt_next = '0;
        end else if (acq_cnt_reg != SAT) begin
          acq_cnt_next = acq_cnt_reg + ONE;
        end
      end
      done_next = (state_reg == CONV) && (state_next == TRACK);
    end
    sh_ena_next   = (state_next != OFF);
    sh_hold_next  = (state_next == SETTLE) || (state_next == CONV);
    conv_req_next = (state_next == CONV);
    busy_next     = sh_hold_next || pending_next;
    ready_next    = (state_next == TRACK) && (acq_cnt_next >= acq_min) && !pending_next;
  end

  assign bus.sh_ena   = sh_ena_reg;
  assign bus.sh_hold  = sh_hold_reg;
  assign bus.conv_req = conv_req_reg;
  assign bus.ready    = ready_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.overrun  = overrun_reg;

endmodule

// File: tb/tb_sample_hold_ctrl.sv
// tb_sample_hold_ctrl: table-driven directed test of sample_hold_ctrl plus
// hand-written sequences for abort, zero timings and asynchronous reset.
// Output vector order: {sh_ena, sh_hold, conv_req, ready, busy, done, overrun}.
module tb_sample_hold_ctrl;
  import sample_hold_pkg::*;

  localparam int W = CNT_W_DEFAULT;

  typedef struct packed {
    logic       en;
    logic       st;
    logic       ack;
    logic [6:0] exp;
  } vec_t;

  logic clk;
  logic resetn;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];
  logic [6:0] obs;

  sample_hold_ctrl_if #(.CNT_W(W)) bus ();

  sample_hold_ctrl #(.CNT_W(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {bus.sh_ena, bus.sh_hold, bus.conv_req, bus.ready, bus.busy, bus.done, bus.overrun};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic en, input logic st, input logic ack, input logic [6:0] exp, input int n);
    for (int k = 0; k < n; k++) tbl.push_back('{en: en, st: st, ack: ack, exp: exp});
  endtask

  task automatic check_vec(input string name, input logic [6:0] got, input logic [6:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: outputs %b, required %b", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  // Ticks until obs[idx] is 1 (bounded); n returns the number of ticks taken.
  task automatic wait_bit(input int idx, input string name, output int n);
    n = 0;
    while (obs[idx] !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (obs[idx] !== 1'b1) begin
      errors++;
      $display("FAIL %s: timed out after %0d cycles", name, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int nd;
    int cyc;
    int dc[3];
    logic done_seen;

    // t_wake=5, t_acq=4, t_settle=3 throughout the table.
    add(1, 1, 0, 7'b0000000, 1);  // 0: reset state; start in OFF ignored
    add(1, 0, 0, 7'b1000000, 9);  // 1-9: WAKE x5, TRACK acq 0..3
    add(1, 1, 0, 7'b1001000, 1);  // 10: ready, start accepted
    add(1, 0, 0, 7'b1100100, 1);  // 11: SETTLE
    add(1, 0, 1, 7'b1100100, 1);  // 12: SETTLE, stray ack ignored
    add(1, 0, 0, 7'b1100100, 1);  // 13: SETTLE last cycle
    add(1, 0, 0, 7'b1110100, 1);  // 14: CONV
    add(1, 0, 1, 7'b1110100, 1);  // 15: CONV, ack
    add(1, 0, 0, 7'b1000010, 1);  // 16: done, acq 0
    add(1, 1, 0, 7'b1000000, 1);  // 17: acq 1, start queued
    add(1, 0, 0, 7'b1000100, 3);  // 18-20: pending, acq 2..4 (taken at 4)
    add(1, 0, 0, 7'b1100100, 3);  // 21-23: SETTLE
    add(1, 1, 0, 7'b1110100, 1);  // 24: CONV, start queued
    add(1, 1, 0, 7'b1110100, 1);  // 25: start dropped
    add(1, 1, 0, 7'b1110101, 1);  // 26: overrun, start dropped
    add(1, 0, 1, 7'b1110101, 1);  // 27: overrun, ack
    add(1, 0, 0, 7'b1000110, 1);  // 28: done, still pending
    add(1, 0, 0, 7'b1000100, 4);  // 29-32: pending, acq 1..4
    add(1, 0, 0, 7'b1100100, 3);  // 33-35: SETTLE
    add(1, 0, 1, 7'b1110100, 1);  // 36: CONV, ack
    add(1, 0, 0, 7'b1000010, 1);  // 37: done
    add(1, 0, 0, 7'b1000000, 1);  // 38: TRACK acq 1

    resetn       = 1'b0;
    bus.enable   = 1'b0;
    bus.start    = 1'b0;
    bus.conv_ack = 1'b0;
    bus.t_wake   = 8'd5;
    bus.t_acq    = 8'd4;
    bus.t_settle = 8'd3;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      $display("row %0d en=%b start=%b ack=%b out=%b exp=%b",
               i, tbl[i].en, tbl[i].st, tbl[i].ack, obs, tbl[i].exp);
      check_vec($sformatf("row%0d", i), obs, tbl[i].exp);
      bus.enable   = tbl[i].en;
      bus.start    = tbl[i].st;
      bus.conv_ack = tbl[i].ack;
      tick();
    end
    bus.start    = 1'b0;
    bus.conv_ack = 1'b0;

    // Abort during conversion with a start queued.
    wait_bit(3, "abort_ready", n);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_bit(4, "abort_conv", n);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_vec("abort_queued", obs, 7'b1110100);
    bus.enable = 1'b0;
    tick();
    $display("abort out=%b", obs);
    check_vec("abort_outputs", obs, 7'b0000000);
    done_seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.done === 1'b1 || obs !== 7'b0000000) done_seen = 1'b1;
    end
    check_int("abort_quiet", int'(done_seen), 0);

    // Re-enable: full wake (5) plus acquisition (4) before ready.
    bus.enable = 1'b1;
    tick();
    check_vec("reenable_wake", obs, 7'b1000000);
    wait_bit(3, "reenable_ready", n);
    $display("reenable ready after %0d cycles", n + 1);
    check_int("reenable_latency", n + 1, 10);

    // Zero timing fields behave as 1.
    bus.enable = 1'b0;
    tick();
    bus.t_wake   = 8'd0;
    bus.t_acq    = 8'd0;
    bus.t_settle = 8'd0;
    bus.enable   = 1'b1;
    tick();
    wait_bit(3, "zero_ready", n);
    $display("zero wake ready after %0d cycles", n + 1);
    check_int("zero_wake_latency", n + 1, 3);

    bus.conv_ack = 1'b1;
    cyc = 0;
    nd  = 0;
    while (nd < 3 && cyc < 40) begin
      bus.start = bus.ready;
      tick();
      cyc++;
      if (bus.done === 1'b1) begin
        dc[nd] = cyc;
        nd++;
        $display("zero period done at cycle %0d", cyc);
      end
    end
    bus.start    = 1'b0;
    bus.conv_ack = 1'b0;
    check_int("zero_done_count", nd, 3);
    if (nd == 3) begin
      check_int("zero_period_1", dc[1] - dc[0], 4);
      check_int("zero_period_2", dc[2] - dc[1], 4);
    end

    // Asynchronous reset in the middle of SETTLE.
    bus.t_settle = 8'd5;
    bus.t_acq    = 8'd1;
    wait_bit(3, "arst_ready", n);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_vec("arst_settle", obs, 7'b1100100);
    tick();
    #2;
    resetn = 1'b0;
    #1;
    $display("async reset out=%b", obs);
    check_vec("async_reset", obs, 7'b0000000);
    #3;
    resetn = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
